// File: rtl/sata_rx_prim_decoder.sv
// Receive-side primitive decoder between the SATA phy and link layers.
// Classifies each dword, strips ALIGNs and expands CONT runs; all outputs registered.
module sata_rx_prim_decoder #(
   parameter int unsigned STABLE_COUNT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        phy_ready,
   input  logic [31:0] rx_din,
   input  logic [3:0]  rx_is_k,
   input  logic        err_clear,
   output logic [31:0] data_dout,
   output logic        data_valid,
   output logic        prim_valid,
   output logic [3:0]  prim,
   output logic        prim_stable,
   output logic        align_seen,
   output logic        rx_err,
   output logic [15:0] err_count
);

   localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
   localparam logic [31:0] PRIM_CONT  = 32'h9999_AA7C;
   localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
   localparam logic [31:0] PRIM_X_RDY = 32'h5757_B57C;
   localparam logic [31:0] PRIM_R_RDY = 32'h4A4A_957C;
   localparam logic [31:0] PRIM_R_IP  = 32'h5555_B57C;
   localparam logic [31:0] PRIM_R_OK  = 32'h3535_B57C;
   localparam logic [31:0] PRIM_R_ERR = 32'h5656_B57C;
   localparam logic [31:0] PRIM_SOF   = 32'h3737_B57C;
   localparam logic [31:0] PRIM_EOF   = 32'hD5D5_B57C;
   localparam logic [31:0] PRIM_WTRM  = 32'h5858_B57C;
   localparam logic [31:0] PRIM_HOLD  = 32'hD5D5_AA7C;
   localparam logic [31:0] PRIM_HOLDA = 32'h9595_AA7C;

   localparam logic [3:0] CODE_NONE    = 4'h0;
   localparam logic [3:0] CODE_UNKNOWN = 4'hF;

   logic [3:0]  last_prim, prev_prim;
   logic        cont_mode;
   logic [7:0]  run_count;

   logic [3:0]  match_code;
   logic        is_align, is_cont;

   logic        n_data_valid, n_prim_valid, n_stable, n_align, n_err, n_cont;
   logic [3:0]  n_prim, n_last_prim, n_prev_prim;
   logic [7:0]  n_run;
   logic [15:0] n_err_count;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      match_code = CODE_NONE;
      is_align   = 1'b0;
      is_cont    = 1'b0;
      case (rx_din)
         PRIM_ALIGN: is_align   = 1'b1;
         PRIM_CONT:  is_cont    = 1'b1;
         PRIM_SYNC:  match_code = 4'h1;
         PRIM_X_RDY: match_code = 4'h2;
         PRIM_R_RDY: match_code = 4'h3;
         PRIM_R_IP:  match_code = 4'h4;
         PRIM_R_OK:  match_code = 4'h5;
         PRIM_R_ERR: match_code = 4'h6;
         PRIM_SOF:   match_code = 4'h7;
         PRIM_EOF:   match_code = 4'h8;
         PRIM_WTRM:  match_code = 4'h9;
         PRIM_HOLD:  match_code = 4'hA;
         PRIM_HOLDA: match_code = 4'hB;
         default:    ;
      endcase
   end

   always_comb begin
      n_data_valid = 1'b0;
      n_prim_valid = 1'b0;
      n_prim       = CODE_NONE;
      n_align      = 1'b0;
      n_err        = 1'b0;
      n_last_prim  = last_prim;
      n_cont       = cont_mode;
      n_run        = run_count;
      n_prev_prim  = prev_prim;

      if (!phy_ready) begin
         n_last_prim = CODE_NONE;
         n_cont      = 1'b0;
         n_run       = 8'd0;
      end else if (rx_is_k == 4'b0000) begin
         if (cont_mode) begin
            // Scrambled filler inside a CONT run repeats the held primitive.
            n_prim_valid = 1'b1;
            n_prim       = last_prim;
         end else begin
            n_data_valid = 1'b1;
            n_last_prim  = CODE_NONE;
            n_run        = 8'd0;
         end
      end else if (rx_is_k == 4'b0001 && is_align) begin
         n_align = 1'b1;
      end else if (rx_is_k == 4'b0001 && is_cont) begin
         if (last_prim != CODE_NONE) begin
            n_cont       = 1'b1;
            n_prim_valid = 1'b1;
            n_prim       = last_prim;
         end else begin
            n_err = 1'b1;
         end
      end else if (rx_is_k == 4'b0001 && match_code != CODE_NONE) begin
         n_prim_valid = 1'b1;
         n_prim       = match_code;
         n_last_prim  = match_code;
         n_cont       = 1'b0;
      end else begin
         n_prim_valid = 1'b1;
         n_prim       = CODE_UNKNOWN;
         n_err        = 1'b1;
         n_last_prim  = CODE_NONE;
         n_cont       = 1'b0;
         n_run        = 8'd0;
      end

      if (n_prim_valid && n_prim != CODE_UNKNOWN) begin
         if (n_prim == prev_prim)
            n_run = (run_count == 8'd255) ? run_count : run_count + 8'd1;
         else
            n_run = 8'd1;
      end
      if (n_prim_valid)
         n_prev_prim = n_prim;

      n_stable = n_prim_valid && (n_prim != CODE_UNKNOWN) && (32'(n_run) >= STABLE_COUNT);

      // Clear takes effect before the same-cycle error is counted.
      n_err_count = err_clear ? 16'd0 : err_count;
      if (n_err && n_err_count != 16'hFFFF)
         n_err_count = n_err_count + 16'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_dout   <= 32'd0;
         data_valid  <= 1'b0;
         prim_valid  <= 1'b0;
         prim        <= CODE_NONE;
         prim_stable <= 1'b0;
         align_seen  <= 1'b0;
         rx_err      <= 1'b0;
         err_count   <= 16'd0;
         last_prim   <= CODE_NONE;
         prev_prim   <= CODE_NONE;
         cont_mode   <= 1'b0;
         run_count   <= 8'd0;
      end else begin
         if (n_data_valid)
            data_dout <= rx_din;
         data_valid  <= n_data_valid;
         prim_valid  <= n_prim_valid;
         prim        <= n_prim;
         prim_stable <= n_stable;
         align_seen  <= n_align;
         rx_err      <= n_err;
         err_count   <= n_err_count;
         last_prim   <= n_last_prim;
         prev_prim   <= n_prev_prim;
         cont_mode   <= n_cont;
         run_count   <= n_run;
      end
   end

endmodule

// File: tb/tb_sata_rx_prim_decoder.sv
// Self-checking bench for sata_rx_prim_decoder: directed scenarios plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_sata_rx_prim_decoder;

   logic        clk = 1'b0;
   logic        rst, phy_ready, err_clear;
   logic [31:0] rx_din;
   logic [3:0]  rx_is_k;
   logic [31:0] data_dout;
   logic        data_valid, prim_valid, prim_stable, align_seen, rx_err;
   logic [3:0]  prim;
   logic [15:0] err_count;

   sata_rx_prim_decoder #(.STABLE_COUNT(3)) dut (
      .clk(clk), .rst(rst), .phy_ready(phy_ready), .rx_din(rx_din), .rx_is_k(rx_is_k),
      .err_clear(err_clear), .data_dout(data_dout), .data_valid(data_valid),
      .prim_valid(prim_valid), .prim(prim), .prim_stable(prim_stable),
      .align_seen(align_seen), .rx_err(rx_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
   localparam logic [31:0] CONT  = 32'h9999_AA7C;

   // Primitive dword by output code; index 0 and 12..15 unused.
   logic [31:0] prim_tab [16];
   initial begin
      prim_tab = '{default: 32'h0};
      prim_tab[1]  = 32'hB5B5_957C; prim_tab[2]  = 32'h5757_B57C;
      prim_tab[3]  = 32'h4A4A_957C; prim_tab[4]  = 32'h5555_B57C;
      prim_tab[5]  = 32'h3535_B57C; prim_tab[6]  = 32'h5656_B57C;
      prim_tab[7]  = 32'h3737_B57C; prim_tab[8]  = 32'hD5D5_B57C;
      prim_tab[9]  = 32'h5858_B57C; prim_tab[10] = 32'hD5D5_AA7C;
      prim_tab[11] = 32'h9595_AA7C;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: held primitive, CONT flag, run of identical valid prims since the last break.
   int        m_last;
   bit        m_cont;
   int        m_run_q[$];
   int        m_err;
   logic [31:0] m_dout;

   bit          chk_en = 1'b0;
   logic        e_dv, e_pv, e_st, e_al, e_err;
   logic [3:0]  e_prim;

   function automatic int lookup(input logic [31:0] d);
      for (int c = 1; c <= 11; c++)
         if (prim_tab[c] == d) return c;
      return 0;
   endfunction

   task automatic model(input logic r, input logic p, input logic [31:0] d,
                        input logic [3:0] k, input logic c);
      int code;
      e_dv = 0; e_pv = 0; e_prim = 0; e_st = 0; e_al = 0; e_err = 0;
      if (r) begin
         m_last = 0; m_cont = 0; m_run_q.delete(); m_err = 0; m_dout = 0;
         return;
      end
      if (!p) begin
         m_last = 0; m_cont = 0; m_run_q.delete();
      end else if (k == 4'b0000) begin
         if (m_cont) begin
            e_pv = 1; e_prim = 4'(m_last);
         end else begin
            e_dv = 1; m_dout = d; m_last = 0; m_run_q.delete();
         end
      end else if (k == 4'b0001 && d == ALIGN) begin
         e_al = 1;
      end else if (k == 4'b0001 && d == CONT) begin
         if (m_last != 0) begin
            m_cont = 1; e_pv = 1; e_prim = 4'(m_last);
         end else e_err = 1;
      end else begin
         code = (k == 4'b0001) ? lookup(d) : 0;
         if (code != 0) begin
            e_pv = 1; e_prim = 4'(code); m_last = code; m_cont = 0;
         end else begin
            e_pv = 1; e_prim = 4'hF; e_err = 1; m_last = 0; m_cont = 0; m_run_q.delete();
         end
      end
      if (e_pv && e_prim != 4'hF) begin
         if (m_run_q.size() > 0 && m_run_q[$] != int'(e_prim)) m_run_q.delete();
         if (m_run_q.size() < 255) m_run_q.push_back(int'(e_prim));
         e_st = (m_run_q.size() >= 3);
      end
      if (c) m_err = 0;
      if (e_err && m_err < 65535) m_err++;
   endtask

   // Drive one cycle at the falling edge and advance the model to match.
   task automatic step(input logic r, input logic p, input logic [31:0] d,
                       input logic [3:0] k, input logic c);
      @(negedge clk);
      rst = r; phy_ready = p; rx_din = d; rx_is_k = k; err_clear = c;
      model(r, p, d, k, c);
      chk_en = 1'b1;
   endtask

   task automatic kp(input int code);
      step(0, 1, prim_tab[code], 4'b0001, 0);
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("data_valid",  32'(data_valid),  32'(e_dv));
         check("prim_valid",  32'(prim_valid),  32'(e_pv));
         check("prim",        32'(prim),        32'(e_prim));
         check("prim_stable", 32'(prim_stable), 32'(e_st));
         check("align_seen",  32'(align_seen),  32'(e_al));
         check("rx_err",      32'(rx_err),      32'(e_err));
         check("err_count",   32'(err_count),   32'(m_err));
         check("data_dout",   data_dout,        m_dout);
      end
   end

   logic [31:0] last_d;
   logic [3:0]  last_k;

   initial begin
      rst = 1; phy_ready = 0; rx_din = 0; rx_is_k = 0; err_clear = 0;
      repeat (2) step(1, 0, 0, 0, 0);
      check("model_reset_errcnt", 32'(m_err), 0);

      // 1: SYNC x4, stable from third output
      kp(1); check("t1_model_prim", 32'(e_prim), 1); check("t1_model_st1", 32'(e_st), 0);
      kp(1);
      kp(1); check("t1_model_st3", 32'(e_st), 1);
      kp(1);

      // 2: X_RDY,X_RDY,CONT, 5 data -> 8 outputs of X_RDY, then SOF
      kp(2); kp(2);
      step(0, 1, CONT, 4'b0001, 0);
      for (int i = 0; i < 5; i++) step(0, 1, $urandom, 4'b0000, 0);
      check("t2_model_prim", 32'(e_prim), 2); check("t2_model_dv", 32'(e_dv), 0);
      kp(7); check("t2_model_sof", 32'(e_prim), 7);
      step(0, 1, 32'hCAFE_F00D, 4'b0000, 0); check("t2_model_cont_cleared", 32'(e_dv), 1);

      // 3: ALIGNs are transparent to the run count
      kp(1);
      step(0, 1, ALIGN, 4'b0001, 0); check("t3_model_align", 32'(e_al), 1);
      step(0, 1, ALIGN, 4'b0001, 0);
      kp(1); check("t3_model_st2", 32'(e_st), 0);
      kp(1); check("t3_model_st3", 32'(e_st), 1);

      // 4: data then orphan CONT
      step(0, 1, 32'h1234_5678, 4'b0000, 0); check("t4_model_dout", m_dout, 32'h1234_5678);
      step(0, 1, CONT, 4'b0001, 0);
      check("t4_model_err", 32'(e_err), 1); check("t4_model_pv", 32'(e_pv), 0);
      check("t4_model_errcnt", 32'(m_err), 1);

      // 5: illegal K mask, unknown K dword, then clear with a third error
      step(1, 0, 0, 0, 0);
      step(0, 1, prim_tab[1], 4'b0011, 0); check("t5_model_prim_f", 32'(e_prim), 15);
      step(0, 1, 32'hFFFF_FF7C, 4'b0001, 0); check("t5_model_errcnt2", 32'(m_err), 2);
      step(0, 1, 32'hFFFF_FF7C, 4'b0001, 1); check("t5_model_clear", 32'(m_err), 1);

      // 6: phy_ready drop mid CONT run
      kp(2); step(0, 1, CONT, 4'b0001, 0); step(0, 1, 32'h5A5A_5A5A, 4'b0000, 0);
      step(0, 0, 32'h5A5A_5A5A, 4'b0000, 0); check("t6_model_idle", 32'(e_pv), 0);
      step(0, 1, 32'hA5A5_A5A5, 4'b0000, 0); check("t6_model_data", 32'(e_dv), 1);

      // Long SYNC run past run-count saturation
      for (int i = 0; i < 300; i++) kp(1);
      check("sat_model_st", 32'(e_st), 1);

      // Random traffic
      last_d = prim_tab[1]; last_k = 4'b0001;
      for (int i = 0; i < 4000; i++) begin
         int r;
         logic [31:0] d;
         logic [3:0]  k;
         r = int'($urandom_range(0, 99));
         if (r < 30)      begin d = last_d;                          k = last_k; end
         else if (r < 45) begin d = $urandom;                        k = 4'b0000; end
         else if (r < 52) begin d = ALIGN;                           k = 4'b0001; end
         else if (r < 62) begin d = CONT;                            k = 4'b0001; end
         else if (r < 85) begin d = prim_tab[$urandom_range(1, 11)]; k = 4'b0001; end
         else if (r < 93) begin d = {$urandom_range(0, 32'hFF_FFFF), 8'h7C}; k = 4'b0001; end
         else             begin d = $urandom; k = 4'($urandom_range(2, 15)); end
         last_d = d; last_k = k;
         step(0, ($urandom_range(0, 99) >= 3), d, k, ($urandom_range(0, 99) < 4));
      end

      @(negedge clk);
      chk_en = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
